// File: rtl/seg_pkg.sv
// Shared constants and the glyph table for the 7-segment display paths.
// Segment vectors are {g,f,e,d,c,b,a}, active low (0 = segment lit).
// Codes 0..9 are decimal digits, 10..26 letters/symbols, 27..30 have no glyph, 31 is blank.
package seg_pkg;

  localparam int NDIG   = 4;
  localparam int NGLYPH = 32;

  typedef logic [4:0] glyph_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] dig_idx_t;

  localparam glyph_t GLYPH_BLANK = 5'd31;
  localparam seg_t   SEG_OFF     = 7'b1111111;

  // Codes without a drawable glyph are stored as SEG_OFF so they show blank.
  localparam seg_t GLYPH_TAB [NGLYPH] = '{
    7'b1000000,  //  0: 0
    7'b1111001,  //  1: 1
    7'b0100100,  //  2: 2
    7'b0110000,  //  3: 3
    7'b0011001,  //  4: 4
    7'b0010010,  //  5: 5
    7'b0000010,  //  6: 6
    7'b1111000,  //  7: 7
    7'b0000000,  //  8: 8
    7'b0010000,  //  9: 9
    7'b0001000,  // 10: A
    7'b0000011,  // 11: b
    7'b1000110,  // 12: C
    7'b0100001,  // 13: d
    7'b0000110,  // 14: E
    7'b0001110,  // 15: F
    7'b0001001,  // 16: H
    7'b1000111,  // 17: L
    7'b0001100,  // 18: P
    7'b1000001,  // 19: U
    7'b0101011,  // 20: n
    7'b0100011,  // 21: o
    7'b0101111,  // 22: r
    7'b0000111,  // 23: t
    7'b0010001,  // 24: y
    7'b0111111,  // 25: -
    7'b1110111,  // 26: _
    SEG_OFF,     // 27: no glyph
    SEG_OFF,     // 28: no glyph
    SEG_OFF,     // 29: no glyph
    SEG_OFF,     // 30: no glyph
    SEG_OFF      // 31: blank
  };

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: glyph word and blink mask in, multiplexed pins and frame pulse out.
// Ports: disp_in[19:0] {d3,d2,d1,d0}, blink_mask[3:0], an[3:0] (active low), seg[6:0] (active low), frame_done.
// slave = the scanner, master = whoever supplies the word and consumes the pins.
interface seg_scan_if;

  logic [19:0] disp_in;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  modport master (
    output disp_in,
    output blink_mask,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  disp_in,
    input  blink_mask,
    output an,
    output seg,
    output frame_done
  );

endinterface

// File: rtl/seg_decode.sv
// Glyph code to active-low segment pattern lookup; purely combinational, zero latency.
// Ports: code[4:0] glyph code in, seg[6:0] {g,f,e,d,c,b,a} out.
// No flow control; output follows input in the same cycle.
module seg_decode
  import seg_pkg::*;
(
  input  glyph_t code,
  output seg_t   seg
);

  assign seg = GLYPH_TAB[code];

endmodule

// File: rtl/seg_scan.sv
// Scans a 4-digit glyph word onto a common-anode 7-segment display with dead time and blinking.
// Ports: clk, rst_n (async, active low), bus (seg_scan_if.slave: disp_in, blink_mask in; an, seg, frame_done out).
// Pins are registered one cycle behind the scan counters; there is no backpressure, the word is sampled once per frame.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned BLINK_DIV   = 64
)
(
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_END   = SW'(DEAD_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [SW-1:0]         slot_cnt;
  dig_idx_t              idx;
  logic                  blink_ph;
  logic [FW-1:0]         frame_cnt;
  glyph_t [NDIG-1:0]     shadow;

  logic slot_last;
  logic frame_end;
  logic dead;
  logic blanked;
  seg_t glyph;
  logic [3:0] an_nxt;
  seg_t       seg_nxt;

  assign slot_last = (slot_cnt == SLOT_LAST);
  // Digit 0 is the last slot of a frame; its final cycle closes the frame.
  assign frame_end = slot_last && (idx == 2'd0);
  assign dead      = (slot_cnt < DEAD_END);
  assign blanked   = blink_ph && bus.blink_mask[idx];

  seg_decode u_decode (
    .code (shadow[idx]),
    .seg  (glyph)
  );

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_OFF;
    if (!dead && !blanked) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = glyph;
    end
  end

  // Scan position: slot counter within a digit, digit index stepping 3 down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= 2'd3;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == 2'd0) ? 2'd3 : idx - 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The word is only captured as the scan re-enters digit 3, so a frame never mixes two words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= {NDIG{GLYPH_BLANK}};
    end else if (frame_end) begin
      shadow <= bus.disp_in;
    end
  end

  // Blink phase flips after every BLINK_DIV completed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= 4'b1111;
      bus.seg        <= SEG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at SCAN_DIV=8, DEAD_CYCLES=2, BLINK_DIV=2.
// Each frame is checked cycle by cycle against hand-written per-digit segment values.
// Outputs are sampled 1 time unit after the rising edge.
module tb_seg_scan;

  localparam int SCAN  = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = SCAN * 4;

  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  seg_scan_if bus ();

  seg_scan #(
    .SCAN_DIV    (SCAN),
    .DEAD_CYCLES (DEAD),
    .BLINK_DIV   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 32-cycle frame. s3..s0 are the segment patterns expected for digits 3..0.
  // If chg_at >= 0, disp_in is replaced by chg_val after that many cycles of the frame.
  task automatic run_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] mask,
                           input int chg_at, input logic [19:0] chg_val);
    logic [6:0] se [4];
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int c, slot, k, ph;
    se[3] = s3; se[2] = s2; se[1] = s1; se[0] = s0;
    one = 4'b0001;
    bus.blink_mask = mask;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      // Pins show the scan state of the previous cycle.
      c    = cyc - 1;
      slot = c % SCAN;
      k    = 3 - ((c / SCAN) % 4);
      ph   = ((c / FRAME) / 2) % 2;
      if (slot < DEAD || (ph == 1 && mask[k])) begin
        exp_an  = 4'b1111;
        exp_seg = SB;
      end else begin
        exp_an  = ~(one << k);
        exp_seg = se[k];
      end
      check("an", {28'd0, bus.an}, {28'd0, exp_an});
      check("seg", {25'd0, bus.seg}, {25'd0, exp_seg});
      check("frame_done", {31'd0, bus.frame_done}, {31'd0, (cyc % FRAME) == 0});
      if (i == chg_at) bus.disp_in = chg_val;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    bus.disp_in    = {5'd1, 5'd2, 5'd3, 5'd4};
    bus.blink_mask = 4'b0000;

    repeat (3) tick();
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);

    @(negedge clk);
    bus.disp_in = {5'd8, 5'd1, 5'd0, 5'd9};
    rst_n = 1'b1;

    // Frame 1 blank, frame 2 shows 8 1 0 9.
    run_frame(SB, SB, SB, SB, 4'b0000, -1, 20'd0);
    run_frame(S8, S1, S0, S9, 4'b0000, -1, 20'd0);
    // Word goes blank while digit 1 is lit: this frame keeps the old word.
    run_frame(S8, S1, S0, S9, 4'b0000, 20, {4{5'd31}});
    run_frame(SB, SB, SB, SB, 4'b0000, 5, {4{5'd8}});
    // Digit 0 blinks: lit two frames, blank two frames, lit again.
    run_frame(S8, S8, S8, S8, 4'b0001, -1, 20'd0);
    run_frame(S8, S8, S8, S8, 4'b0001, -1, 20'd0);
    run_frame(S8, S8, S8, S8, 4'b0001, -1, 20'd0);
    run_frame(S8, S8, S8, S8, 4'b0001, -1, 20'd0);
    run_frame(S8, S8, S8, S8, 4'b0001, 10, {5'd27, 5'd28, 5'd29, 5'd30});
    // Codes without a glyph show blank while the anodes keep scanning.
    run_frame(SB, SB, SB, SB, 4'b0000, -1, 20'd0);

    // Mid-slot reset: digit 3 is lit, then reset forces the pins off immediately.
    repeat (4) tick();
    check("pre_rst_an", {28'd0, bus.an}, 32'h7);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", {28'd0, bus.an}, 32'hF);
    check("mid_rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("mid_rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Scanning restarts at digit 3, slot 0, with a blank shadow.
    run_frame(SB, SB, SB, SB, 4'b0000, -1, 20'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
